alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- ID/EX issue stage that produces the ALU's control and operand inputs.
- Accepts a decoded-register-read bundle (instruction word plus rs1/rs2 values) over a valid/ready handshake.
- Decodes OP and OP-IMM RV32I instructions into alu_fn_t, funct7_t, operands and rd, and presents them registered to the ALU.
- A 2-entry skid buffer gives full throughput with registered ready; decoding errors are flagged and counted.

Parameters:
- WIDTH, 32, datapath width of operands (RV32I semantics require 32).
- CNT_WIDTH, 16, width of the illegal-instruction counter (saturating).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept; registered, equals !skid_full.
- instr  in  32  instruction word.
- rs1_val  in  WIDTH  register rs1 contents.
- rs2_val  in  WIDTH  register rs2 contents.
- flush  in  1  discard all held entries (branch redirect).
- out_valid  out  1  ALU bundle valid.
- out_ready  in  1  EX stage accepts bundle.
- fn  out  alu_fn_t  ALU function (funct3 encoding).
- funct7  out  funct7_t  ADD_SRL or SUB_SRA.
- a  out  WIDTH  ALU operand a.
- b  out  WIDTH  ALU operand b.
- rd  out  5  destination register.
- illegal  out  1  bundle is an illegal instruction marker.
- illegal_cnt  out  CNT_WIDTH  count of illegal bundles issued.

Behaviour:
- Reset values:
  - out_valid=0, in_ready=1, fn=ADD_SUB, funct7=ADD_SRL, a=b=0, rd=0, illegal=0, illegal_cnt=0.
  - Skid buffer is empty.
- Handshake:
  - Transfer in occurs when in_valid&in_ready; transfer out when out_valid&out_ready.
  - Output fields are stable while out_valid&!out_ready.
- Latency: an accepted bundle appears on the outputs the next cycle if the output register is empty or draining.
- Skid buffer:
  - If the output register holds a stalled bundle, an accepted input goes to the skid entry and in_ready drops the following cycle.
  - When the output register drains, the skid entry moves into it and in_ready rises the next cycle.
  - Order is preserved.
- Decode, opcode 0110011 (OP):
  - fn=instr[14:12], a=rs1_val, b=rs2_val, rd=instr[11:7].
  - instr[31:25]=0000000 gives funct7=ADD_SRL.
  - instr[31:25]=0100000 with funct3 000 or 101 gives funct7=SUB_SRA.
  - Any other instr[31:25] is illegal.
- Decode, opcode 0010011 (OP-IMM):
  - a=rs1_val; b=sign-extended instr[31:20].
  - funct7=ADD_SRL, except funct3=101 with instr[30]=1, which gives SUB_SRA (SRAI).
  - ADDI never subtracts.
  - Shifts (funct3 001/101): b=zero-extended instr[24:20].
  - imm[11:5] must be 0000000, or 0100000 for SRAI only; otherwise illegal.
- Illegal bundle (any other opcode or bad funct7):
  - Issued in order with illegal=1, fn=ADD_SUB, funct7=ADD_SRL, a=b=0, rd=0.
  - illegal_cnt increments when an illegal bundle transfers out, saturating at all-ones.
- Flush:
  - Both entries are cleared; out_valid=0 the next cycle and in_ready=1 the next cycle.
  - A simultaneous input transfer is dropped; flush has priority.
  - illegal_cnt is not affected.
- Simultaneous in and out transfers with one entry held keep occupancy at 1 and sustain 1 bundle/cycle.
- Reset asserted mid-operation forces the reset values immediately (asynchronous), discarding held bundles.

Decomposition:
- Package ALU_FNS (extend the existing one):
  - alu_fn_t (3-bit: ADD_SUB=000, SLL=001, SLT=010, SLTU=011, XOR=100, SRL_SRA=101, OR=110, AND=111).
  - funct7_t (1-bit: ADD_SRL=0, SUB_SRA=1).
  - Opcode constants OPC_OP=7'b0110011 and OPC_OP_IMM=7'b0010011.
  - Packed struct alu_bundle_t holding fn, funct7, a, b, rd, illegal.
- Sub-module alu_skid_buf: generic 2-entry valid/ready buffer carrying alu_bundle_t, holding the flush logic.
- alu_issue contains the combinational decoder, the buffer instance and the counter.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=0xFFFFFFFA, out_ready=1 -> next cycle out_valid=1, fn=ADD_SUB, funct7=ADD_SRL, a=5, b=0xFFFFFFFA, rd=3.
- SUB (0x402081B3) -> funct7=SUB_SRA. ADDI x1,x0,-1 (0xFFF00093) -> fn=ADD_SUB, funct7=ADD_SRL, b=0xFFFFFFFF, rd=1.
- SRAI x5,x6,3 (0x40335293) -> fn=SRL_SRA, funct7=SUB_SRA, b=0x00000003, rd=5. SLLI with imm[11:5]=0100000 (0x40331293) -> illegal=1.
- ECALL (0x00000073) then 0x02208033 (MUL) -> two bundles with illegal=1, a=b=0, rd=0; illegal_cnt=2.
- out_ready=0, three back-to-back in_valid -> two accepted, in_ready=0 from the cycle after the second accept; raise out_ready -> bundles drain in order, one per cycle.
- Stalled with 2 entries, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, no bundle emerges. Assert rst asynchronously between clock edges -> outputs take their reset values immediately.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Purpose: shared ALU issue types: function/funct7 encodings, opcodes, issue bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_issue_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ADD_SUB = 3'b000,
    SLL     = 3'b001,
    SLT     = 3'b010,
    SLTU    = 3'b011,
    XOR     = 3'b100,
    SRL_SRA = 3'b101,
    OR      = 3'b110,
    AND     = 3'b111
  } alu_fn_t;

  typedef enum logic {
    ADD_SRL = 1'b0,
    SUB_SRA = 1'b1
  } funct7_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // funct7 / imm[11:5] patterns that are legal for the base integer ops
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_fn_t          fn;
    funct7_t          funct7;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [4:0]       rd;
    logic             illegal;
  } alu_bundle_t;

  // All-zero bundle: ADD_SUB/ADD_SRL, zero operands, rd=x0, legal
  localparam alu_bundle_t BUNDLE_NOP = '{
    fn: ADD_SUB, funct7: ADD_SRL, a: '0, b: '0, rd: '0, illegal: 1'b0
  };

endpackage

// File: rtl/alu_skid_buf.sv
// Purpose: 2-entry valid/ready buffer (output register + skid entry) with flush.
// Latency: 1 cycle when output register is empty or draining.
// Backpressure: in_ready is registered (= !skid_full); drops the cycle after the skid fills.
// Ports: clk/rst (async active-high); flush clears both entries;
//        in_valid/in_ready/in_data upstream; out_valid/out_ready/out_data downstream.
module alu_skid_buf
  import alu_issue_pkg::*;
#(
  parameter type T = alu_bundle_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic skid_full;
  T     skid_data;
  logic in_fire;

  assign in_ready = !skid_full;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= T'('0);
      skid_full <= 1'b0;
      skid_data <= T'('0);
    end else if (flush) begin
      // flush wins over any simultaneous input transfer
      out_valid <= 1'b0;
      skid_full <= 1'b0;
    end else if (!out_valid || out_ready) begin
      // output register is free this cycle; skid entry is older than input,
      // and in_ready is low whenever the skid is full, so no input is lost
      if (skid_full) begin
        out_data  <= skid_data;
        out_valid <= 1'b1;
        skid_full <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire) out_data <= in_data;
      end
    end else if (in_fire) begin
      // output stalled: park the new bundle in the skid entry
      skid_data <= in_data;
      skid_full <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Purpose: ID/EX issue stage: decodes RV32I OP/OP-IMM into registered ALU controls/operands.
// Latency: 1 cycle from input transfer to outputs when the output register is free.
// Backpressure: 2-entry skid buffer, registered in_ready; full throughput under out_ready=1.
// Ports: clk/rst (async active-high); in_valid/in_ready with instr, rs1_val, rs2_val;
//        flush; out_valid/out_ready with fn, funct7, a, b, rd, illegal; illegal_cnt.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [WIDTH-1:0]     rs1_val,
  input  logic [WIDTH-1:0]     rs2_val,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output alu_fn_t              fn,
  output funct7_t              funct7,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic [4:0]           rd,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] illegal_cnt
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is_shift;
  alu_bundle_t dec;
  alu_bundle_t q;

  assign opc      = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    dec         = BUNDLE_NOP;
    dec.illegal = 1'b1;
    if (opc == OPC_OP) begin
      if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))) begin
        dec.fn      = alu_fn_t'(f3);
        dec.funct7  = (f7 == F7_ALT) ? SUB_SRA : ADD_SRL;
        dec.a       = rs1_val;
        dec.b       = rs2_val;
        dec.rd      = instr[11:7];
        dec.illegal = 1'b0;
      end
    end else if (opc == OPC_OP_IMM) begin
      // imm[11:5] is only constrained for shifts; elsewhere it is immediate data
      if (!is_shift || f7 == F7_BASE || (f7 == F7_ALT && f3 == 3'b101)) begin
        dec.fn      = alu_fn_t'(f3);
        dec.funct7  = (f3 == 3'b101 && instr[30]) ? SUB_SRA : ADD_SRL;
        dec.a       = rs1_val;
        dec.b       = is_shift ? {{(WIDTH-5){1'b0}}, instr[24:20]}
                               : {{(WIDTH-12){instr[31]}}, instr[31:20]};
        dec.rd      = instr[11:7];
        dec.illegal = 1'b0;
      end
    end
  end

  alu_skid_buf #(.T(alu_bundle_t)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (q)
  );

  assign fn      = q.fn;
  assign funct7  = q.funct7;
  assign a       = q.a;
  assign b       = q.b;
  assign rd      = q.rd;
  assign illegal = q.illegal;

  // counts illegal bundles as they leave, so flushed ones are never counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (out_valid && out_ready && q.illegal && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  alu_fn_t     fn;
  funct7_t     funct7;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd;
  logic        illegal;
  logic [15:0] illegal_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int n_out  = 0;
  alu_bundle_t sb[$];

  always #5 clk = ~clk;

  alu_issue #(.WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .fn(fn), .funct7(funct7),
    .a(a), .b(b), .rd(rd), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic alu_bundle_t mk(alu_fn_t f, funct7_t s, logic [31:0] av,
                                     logic [31:0] bv, logic [4:0] r, logic il);
    alu_bundle_t e;
    e.fn = f; e.funct7 = s; e.a = av; e.b = bv; e.rd = r; e.illegal = il;
    return e;
  endfunction

  // scoreboard: an output transfer completes at the next rising edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_out", 32'd1, 32'd0);
      end else begin
        alu_bundle_t e;
        e = sb.pop_front();
        chk("fn", 32'(fn), 32'(e.fn));
        chk("funct7", 32'(funct7), 32'(e.funct7));
        chk("a", a, e.a);
        chk("b", b, e.b);
        chk("rd", 32'(rd), 32'(e.rd));
        chk("illegal", 32'(illegal), 32'(e.illegal));
        n_out++;
      end
    end
  end

  task automatic check_rst(input string p);
    chk({p, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({p, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({p, "_fn"}, 32'(fn), 32'(ADD_SUB));
    chk({p, "_funct7"}, 32'(funct7), 32'(ADD_SRL));
    chk({p, "_a"}, a, 32'd0);
    chk({p, "_b"}, b, 32'd0);
    chk({p, "_rd"}, 32'(rd), 32'd0);
    chk({p, "_illegal"}, 32'(illegal), 32'd0);
    chk({p, "_cnt"}, 32'(illegal_cnt), 32'd0);
  endtask

  // called at posedge+1; returns at posedge+1 after the edge that samples the input
  task automatic send(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                      input alu_bundle_t e, input logic fl, output logic acc);
    instr = i; rs1_val = r1; rs2_val = r2; in_valid = 1'b1; flush = fl;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk); #1;
    if (fl) sb.delete();
    else if (acc) sb.push_back(e);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (sb.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    chk("drain_left", sb.size(), 32'd0);
  endtask

  typedef struct {
    logic [31:0] i; logic [31:0] r1; logic [31:0] r2; alu_bundle_t e;
  } vec_t;

  vec_t vecs[$];
  logic acc;
  int   n0;
  alu_bundle_t ill;

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; rs1_val = '0; rs2_val = '0;
    flush = 1'b0; out_ready = 1'b0;
    ill = mk(ADD_SUB, ADD_SRL, 32'd0, 32'd0, 5'd0, 1'b1);
    #3;
    check_rst("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // decode table, streamed with out_ready high
    vecs.push_back('{32'h002081B3, 32'd5, 32'hFFFFFFFA, mk(ADD_SUB, ADD_SRL, 32'd5, 32'hFFFFFFFA, 5'd3, 1'b0)});
    vecs.push_back('{32'h402081B3, 32'd7, 32'd2, mk(ADD_SUB, SUB_SRA, 32'd7, 32'd2, 5'd3, 1'b0)});
    vecs.push_back('{32'hFFF00093, 32'd0, 32'h1234, mk(ADD_SUB, ADD_SRL, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b0)});
    vecs.push_back('{32'h40335293, 32'h80000000, 32'h55, mk(SRL_SRA, SUB_SRA, 32'h80000000, 32'd3, 5'd5, 1'b0)});
    vecs.push_back('{32'h40331293, 32'h11, 32'h22, ill});
    vecs.push_back('{32'h00000073, 32'h33, 32'h44, ill});
    vecs.push_back('{32'h02208033, 32'h55, 32'h66, ill});
    vecs.push_back('{32'h00335293, 32'hF0, 32'h1, mk(SRL_SRA, ADD_SRL, 32'hF0, 32'd3, 5'd5, 1'b0)});
    vecs.push_back('{32'hF0037293, 32'hABCD, 32'h9, mk(AND, ADD_SRL, 32'hABCD, 32'hFFFFFF00, 5'd5, 1'b0)});
    vecs.push_back('{32'h402091B3, 32'h77, 32'h88, ill});
    vecs.push_back('{32'h0020C1B3, 32'h0F0F, 32'h00FF, mk(XOR, ADD_SRL, 32'h0F0F, 32'h00FF, 5'd3, 1'b0)});

    out_ready = 1'b1;
    foreach (vecs[k]) begin
      send(vecs[k].i, vecs[k].r1, vecs[k].r2, vecs[k].e, 1'b0, acc);
      chk("dec_acc", 32'(acc), 32'd1);
      chk("dec_latency_vld", 32'(out_valid), 32'd1);
    end
    idle();
    wait_drain(20);
    chk("illegal_cnt_dec", 32'(illegal_cnt), 32'd4);

    // back-to-back throughput
    n0 = n_out;
    for (int k = 0; k < 8; k++) begin
      send(32'h002081B3, 32'h11111111 * k, ~k, mk(ADD_SUB, ADD_SRL, 32'h11111111 * k, ~k, 5'd3, 1'b0), 1'b0, acc);
      chk("tput_acc", 32'(acc), 32'd1);
      chk("tput_vld", 32'(out_valid), 32'd1);
    end
    idle();
    wait_drain(20);
    chk("tput_count", n_out - n0, 32'd8);

    // stall: two accepted, third refused, then ordered drain
    out_ready = 1'b0;
    send(32'h002081B3, 32'hA, 32'h1, mk(ADD_SUB, ADD_SRL, 32'hA, 32'h1, 5'd3, 1'b0), 1'b0, acc);
    chk("stall_acc1", 32'(acc), 32'd1);
    send(32'h002081B3, 32'hB, 32'h2, mk(ADD_SUB, ADD_SRL, 32'hB, 32'h2, 5'd3, 1'b0), 1'b0, acc);
    chk("stall_acc2", 32'(acc), 32'd1);
    send(32'h002081B3, 32'hC, 32'h3, mk(ADD_SUB, ADD_SRL, 32'hC, 32'h3, 5'd3, 1'b0), 1'b0, acc);
    chk("stall_acc3", 32'(acc), 32'd0);
    chk("stall_hold_a", a, 32'hA);
    idle();
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_vld1", 32'(out_valid), 32'd1);
    chk("drain_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_sb", sb.size(), 32'd0);

    // flush with both entries held and input valid
    out_ready = 1'b0;
    send(32'h00000073, 32'h1, 32'h1, ill, 1'b0, acc);
    send(32'h00000073, 32'h2, 32'h2, ill, 1'b0, acc);
    send(32'h002081B3, 32'h3, 32'h3, ill, 1'b1, acc);
    idle();
    chk("flush2_vld", 32'(out_valid), 32'd0);
    chk("flush2_rdy", 32'(in_ready), 32'd1);

    // flush with one entry held: simultaneous accepted input is dropped
    send(32'h00000073, 32'h4, 32'h4, ill, 1'b0, acc);
    send(32'h002081B3, 32'h5, 32'h5, ill, 1'b1, acc);
    chk("flush1_acc", 32'(acc), 32'd1);
    idle();
    chk("flush1_vld", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("flush_quiet", 32'(out_valid), 32'd0);
    end
    chk("flush_cnt", 32'(illegal_cnt), 32'd4);

    // asynchronous reset between edges while stalled and full
    out_ready = 1'b0;
    send(32'h02208033, 32'h6, 32'h6, ill, 1'b0, acc);
    send(32'h402081B3, 32'h7, 32'h7, mk(ADD_SUB, SUB_SRA, 32'h7, 32'h7, 5'd3, 1'b0), 1'b0, acc);
    idle();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_rst("arst");
    sb.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h0020C1B3, 32'h3C, 32'h0F, mk(XOR, ADD_SRL, 32'h3C, 32'h0F, 5'd3, 1'b0), 1'b0, acc);
    chk("post_rst_acc", 32'(acc), 32'd1);
    idle();
    wait_drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
